// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path feeding the wide adder.
package uart_pkg;

    localparam int unsigned UART_BYTE_W      = 8;
    localparam int unsigned PACKER_NUM_BYTES = 48;
    localparam int unsigned ADDER_OP_WIDTH   = 381;

    typedef enum logic {
        FILL,
        HOLD
    } packer_state_t;

endpackage

// File: rtl/uart_operand_packer_byte_xor_acc.sv
// byte_xor_acc: 8-bit running XOR of accepted bytes with a frame-start clear.
// Only built when UART_PACKER_CHECKSUM_EN is defined; the whole module is
// guarded so the default build carries no orphan top-level module.
`ifdef UART_PACKER_CHECKSUM_EN
module byte_xor_acc
    import uart_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic [UART_BYTE_W-1:0] din,
    output logic [UART_BYTE_W-1:0] acc
);

    // Clear and accumulate in the same cycle seeds the new frame with din.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= en ? din : '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule
`endif

// File: rtl/uart_operand_packer.sv
// uart_operand_packer: gathers UART bytes LSB-first into one wide operand and
// hands it to the adder over valid/ready. Optional checksum byte checking is
// enabled by defining UART_PACKER_CHECKSUM_EN.
module uart_operand_packer
    import uart_pkg::*;
#(
    parameter int unsigned NUM_BYTES = PACKER_NUM_BYTES,
    parameter int unsigned OP_WIDTH  = ADDER_OP_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic [UART_BYTE_W-1:0]          byte_in,
    input  logic                            byte_valid,
    output logic [OP_WIDTH-1:0]             op_data,
    output logic                            op_valid,
    input  logic                            op_ready,
    output logic                            range_err,
    output logic                            chk_err,
    output logic                            overflow,
    output logic [$clog2(NUM_BYTES+2)-1:0]  byte_count
);

    localparam int unsigned SH_W  = UART_BYTE_W * NUM_BYTES;
    localparam int unsigned CNT_W = $clog2(NUM_BYTES + 2);
`ifdef UART_PACKER_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = NUM_BYTES + 1;
`else
    localparam int unsigned FRAME_LEN = NUM_BYTES;
`endif
    // Shadow bits that must be zero for the operand to fit the adder.
    localparam logic [SH_W-1:0] HI_MASK = {SH_W{1'b1}} << OP_WIDTH;

    packer_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]  shadow_q, shadow_d;
    logic             op_valid_q, op_valid_d;
    logic             range_q, range_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             frame_start;
    logic [CNT_W-1:0] idx;

`ifdef UART_PACKER_CHECKSUM_EN
    logic                   chk_q, chk_d;
    logic                   acc_en;
    logic [UART_BYTE_W-1:0] acc_val;

    byte_xor_acc u_xor_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_start),
        .en    (acc_en),
        .din   (byte_in),
        .acc   (acc_val)
    );
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    // Next-state: clear wins, HOLD waits for the handshake, accepted bytes land in the shadow.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        op_valid_d  = op_valid_q;
        range_d     = range_q;
        ovf_d       = ovf_q;
        accept      = 1'b0;
        frame_start = 1'b0;
`ifdef UART_PACKER_CHECKSUM_EN
        chk_d  = chk_q;
        acc_en = 1'b0;
`endif
        // A byte taken during the handshake cycle is byte 0 of the next frame.
        idx = (state_q == HOLD) ? '0 : cnt_q;

        if (clear) begin
            state_d     = FILL;
            cnt_d       = '0;
            shadow_d    = '0;
            op_valid_d  = 1'b0;
            range_d     = 1'b0;
            ovf_d       = 1'b0;
            frame_start = 1'b1;
`ifdef UART_PACKER_CHECKSUM_EN
            chk_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                FILL: accept = byte_valid;
                HOLD: begin
                    if (op_ready) begin
                        state_d     = FILL;
                        op_valid_d  = 1'b0;
                        range_d     = 1'b0;
                        cnt_d       = '0;
                        frame_start = 1'b1;
                        accept      = byte_valid;
`ifdef UART_PACKER_CHECKSUM_EN
                        chk_d = 1'b0;
`endif
                    end else if (byte_valid) begin
                        ovf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (accept) begin
            cnt_d = idx + 1'b1;
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (idx == CNT_W'(i)) begin
                    shadow_d[UART_BYTE_W*i +: UART_BYTE_W] = byte_in;
                end
            end
`ifdef UART_PACKER_CHECKSUM_EN
            acc_en = (idx < CNT_W'(NUM_BYTES));
            // The checksum byte is compared, never stored.
            if (idx == CNT_W'(NUM_BYTES)) begin
                chk_d = (acc_val != byte_in);
            end
`endif
            if (idx == CNT_W'(FRAME_LEN - 1)) begin
                state_d    = HOLD;
                op_valid_d = 1'b1;
                range_d    = |(shadow_d & HI_MASK);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            shadow_q   <= '0;
            op_valid_q <= 1'b0;
            range_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            op_valid_q <= op_valid_d;
            range_q    <= range_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef UART_PACKER_CHECKSUM_EN
    // Checksum verdict, held for the operand it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
        end
    end
    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

    assign op_data    = shadow_q[OP_WIDTH-1:0];
    assign op_valid   = op_valid_q;
    assign range_err  = range_q;
    assign overflow   = ovf_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_uart_operand_packer.sv
// Randomised bench for uart_operand_packer against a queue-based frame model,
// plus directed frames with hand-computed expectations.
module tb_uart_operand_packer;
    import uart_pkg::*;

    localparam int NB = 48;
    localparam int OW = 381;
    localparam int CW = $clog2(NB + 2);
`ifdef UART_PACKER_CHECKSUM_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif

    logic          clk, rst_n, clear, byte_valid, op_ready;
    logic [7:0]    byte_in;
    logic [OW-1:0] op_data;
    logic          op_valid, range_err, chk_err, overflow;
    logic [CW-1:0] byte_count;

    uart_operand_packer #(.NUM_BYTES(NB), .OP_WIDTH(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .op_data    (op_data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .range_err  (range_err),
        .chk_err    (chk_err),
        .overflow   (overflow),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a frame is a list of bytes; the operand is their LSB-first concatenation.
    logic [7:0]    m_frame[$];
    bit            m_valid = 0;
    bit            m_range = 0;
    bit            m_chk   = 0;
    bit            m_ovf   = 0;
    bit            m_known = 1;
    int            m_count = 0;
    logic [OW-1:0] m_data  = '0;

    task automatic m_accept(input logic [7:0] b);
        logic [8*NB-1:0] wide;
        logic [7:0]      x;
        m_frame.push_back(b);
        m_count = m_frame.size();
        m_known = 0;
        if (m_frame.size() == FL) begin
            wide = '0;
            x    = 8'h00;
            for (int i = 0; i < NB; i++) begin
                wide[8*i +: 8] = m_frame[i];
                x = x ^ m_frame[i];
            end
            m_data  = wide[OW-1:0];
            m_range = |(wide >> OW);
            m_chk   = (FL > NB) && (x != m_frame[FL-1]);
            m_valid = 1;
            m_frame.delete();
        end
    endtask

    logic       s_rst, s_clr, s_bv, s_rdy;
    logic [7:0] s_b;

    // Model advances on each edge from the sampled inputs, then outputs are compared.
    always @(posedge clk) begin
        s_rst = rst_n; s_clr = clear; s_bv = byte_valid; s_b = byte_in; s_rdy = op_ready;
        if (!s_rst || s_clr) begin
            m_frame.delete();
            m_valid = 0; m_count = 0; m_ovf = 0; m_range = 0; m_chk = 0;
            m_data  = '0; m_known = 1;
        end else if (m_valid) begin
            if (s_rdy) begin
                m_valid = 0; m_count = 0; m_known = 0;
                if (s_bv) m_accept(s_b);
            end else if (s_bv) begin
                m_ovf = 1;
            end
        end else if (s_bv) begin
            m_accept(s_b);
        end
        #1;
        cmp("op_valid", op_valid, m_valid);
        cmp("byte_count", byte_count, m_count);
        cmp("overflow", overflow, m_ovf);
`ifdef UART_PACKER_CHECKSUM_EN
        if (m_valid) cmp("chk_err", chk_err, m_chk);
`else
        cmp("chk_err_tied", chk_err, 0);
`endif
        if (m_valid) begin
            cmp("range_err", range_err, m_range);
            cmp("op_data", op_data, m_data);
        end else if (m_known) begin
            cmp("op_data_reset", op_data, '0);
        end
    end

    logic [7:0] fd[NB];
`ifdef UART_PACKER_CHECKSUM_EN
    logic [7:0] chk_flip = 8'h00;
`endif

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Sends fd[first..NB-1], plus the checksum over all of fd when enabled.
    task automatic send_frame(input int first);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NB; i++) begin
            x = x ^ fd[i];
            if (i >= first) send(fd[i]);
        end
`ifdef UART_PACKER_CHECKSUM_EN
        send(x ^ chk_flip);
`else
        if (x === 8'hxx) $display("note: undefined frame data");
`endif
    endtask

    task automatic rand_fd();
        for (int i = 0; i < NB; i++) fd[i] = 8'($urandom);
        fd[NB-1] = fd[NB-1] & 8'h1F;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; op_ready = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rst_op_valid", op_valid, 0);
        cmp("rst_count", byte_count, 0);
        cmp("rst_overflow", overflow, 0);
        cmp("rst_op_data", op_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: bytes 1..47 then 0x10.
        op_ready = 1'b1;
        for (int i = 0; i < NB - 1; i++) fd[i] = 8'(i + 1);
        fd[NB-1] = 8'h10;
        send_frame(0);
        cmp("basic_valid", op_valid, 1);
        cmp("basic_b0", op_data[7:0], 8'h01);
        cmp("basic_b1", op_data[15:8], 8'h02);
        cmp("basic_top", op_data[380:376], 5'h10);
        cmp("basic_range", range_err, 0);
        @(negedge clk);
        cmp("basic_one_cycle", op_valid, 0);

        // Range error: top byte 0xE0 lives entirely above bit 380 except zeros.
        fd[NB-1] = 8'hE0;
        send_frame(0);
        cmp("range_valid", op_valid, 1);
        cmp("range_err", range_err, 1);
        cmp("range_top", op_data[380:376], 5'h00);
        @(negedge clk);

        // Backpressure with bytes dropped in HOLD.
        op_ready = 1'b0;
        rand_fd();
        send_frame(0);
        repeat (3) send(8'($urandom));
        cmp("bp_valid", op_valid, 1);
        cmp("bp_overflow", overflow, 1);
        cmp("bp_b0", op_data[7:0], fd[0]);
        op_ready = 1'b1;
        @(negedge clk);
        cmp("bp_released", op_valid, 0);
        cmp("bp_ovf_sticky", overflow, 1);
        cmp("bp_count", byte_count, 0);

        // Handshake and a new byte in the same cycle.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        cmp("clr_overflow", overflow, 0);
        op_ready = 1'b0;
        rand_fd();
        send_frame(0);
        repeat (2) @(negedge clk);
        op_ready = 1'b1;
        send(8'hAA);
        cmp("hsb_count", byte_count, 1);
        cmp("hsb_overflow", overflow, 0);
        rand_fd();
        fd[0] = 8'hAA;
        send_frame(1);
        cmp("hsb_valid", op_valid, 1);
        cmp("hsb_b0", op_data[7:0], 8'hAA);
        @(negedge clk);

        // Reset mid-frame, then a fresh frame.
        repeat (20) send(8'($urandom));
        rst_n = 1'b0;
        @(negedge clk);
        cmp("mrst_count", byte_count, 0);
        cmp("mrst_valid", op_valid, 0);
        cmp("mrst_range", range_err, 0);
        cmp("mrst_chk", chk_err, 0);
        cmp("mrst_data", op_data, 0);
        rst_n = 1'b1;
        rand_fd();
        send_frame(0);
        cmp("mrst_fresh_valid", op_valid, 1);
        cmp("mrst_fresh_b0", op_data[7:0], fd[0]);
        @(negedge clk);

        // Clear mid-frame, colliding with a byte strobe.
        repeat (20) send(8'($urandom));
        clear = 1'b1; byte_valid = 1'b1; byte_in = 8'h55;
        @(negedge clk);
        clear = 1'b0; byte_valid = 1'b0;
        cmp("mclr_count", byte_count, 0);
        cmp("mclr_overflow", overflow, 0);
        cmp("mclr_data", op_data, 0);
        rand_fd();
        send_frame(0);
        cmp("mclr_fresh_valid", op_valid, 1);
        cmp("mclr_fresh_b1", op_data[15:8], fd[1]);
        @(negedge clk);

`ifdef UART_PACKER_CHECKSUM_EN
        // 48 x 0x5A XORs to 0x00.
        for (int i = 0; i < NB; i++) fd[i] = 8'h5A;
        chk_flip = 8'h00;
        send_frame(0);
        cmp("chk_good_valid", op_valid, 1);
        cmp("chk_good", chk_err, 0);
        @(negedge clk);
        chk_flip = 8'h01;
        send_frame(0);
        cmp("chk_bad_valid", op_valid, 1);
        cmp("chk_bad", chk_err, 1);
        @(negedge clk);
        chk_flip = 8'h00;
`endif

        // Random traffic: gaps, backpressure, occasional clear.
        for (int c = 0; c < 4000; c++) begin
            byte_valid = ($urandom_range(0, 3) != 0);
            byte_in    = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom) & 8'h1F;
            op_ready   = ($urandom_range(0, 2) != 0);
            clear      = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        byte_valid = 1'b0; clear = 1'b0; op_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_operand_packer.md
# uart_operand_packer

Byte-to-operand assembler sitting directly downstream of the 8-bit UART receiver and upstream of the 381-bit adder. Collects a frame of received bytes, LSB-first, into one wide operand and presents it to the adder over a valid/ready handshake. Flags oversize operands, dropped bytes and, when configured, checksum mismatches.

## Interface
- `NUM_BYTES`, 48: data bytes per operand frame.
- `OP_WIDTH`, 381: operand width delivered to the adder; must satisfy `OP_WIDTH <= 8*NUM_BYTES`.
- `clk`  in  1  system clock; the receiver's baud-domain clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clear`  in  1  synchronous frame abort; returns the block to FILL with the count at zero.
- `byte_in`  in  8  received byte.
- `byte_valid`  in  1  one-cycle strobe: `byte_in` is a new byte.
- `op_data`  out  `OP_WIDTH`  assembled operand.
- `op_valid`  out  1  operand available.
- `op_ready`  in  1  adder accepts the operand.
- `range_err`  out  1  bits `[8*NUM_BYTES-1:OP_WIDTH]` of the frame were non-zero; valid while `op_valid` is high.
- `chk_err`  out  1  checksum mismatch, sticky until the next frame starts; constant 0 when the feature is compiled out.
- `overflow`  out  1  sticky: a byte arrived in HOLD and was dropped; cleared only by `rst_n` or `clear`.
- `byte_count`  out  `$clog2(NUM_BYTES+2)`  bytes accepted in the current frame.

## Operation
- States: FILL, HOLD.
- **FILL:** each `byte_valid` writes `byte_in` to shadow bits `[8*k+7:8*k]`, where k is `byte_count`, then increments `byte_count`. The shadow register is `8*NUM_BYTES` bits wide.
- **Frame end:** the frame ends when the last byte is accepted (byte `NUM_BYTES-1`, or the checksum byte when the feature is enabled).
  - Go to HOLD.
  - Raise `op_valid`.
  - Set `range_err` from the OR of the shadow bits above `OP_WIDTH`.
  - `op_data` is shadow `[OP_WIDTH-1:0]`.
- **HOLD:** `op_data`, `range_err` and `chk_err` are frozen.
  - Any `byte_valid` here sets `overflow`; the byte is discarded.
  - On `op_valid && op_ready`: drop `op_valid`, zero `byte_count`, return to FILL. The shadow register is not cleared; each frame overwrites every byte.
- **Operand with error flags:** the operand is always presented, even if `range_err` or `chk_err` is set. The adder-side control decides what to do with it.
- **Handshake plus new byte in the same cycle:** the byte is accepted as byte 0 of the next frame and does not set `overflow`.
- **`clear` plus `byte_valid` in the same cycle:** `clear` wins; the byte is dropped and `overflow` is not set.
- **Reset values (`rst_n` low):**
  - `op_valid`=0, `op_data`=0
  - `range_err`=0, `chk_err`=0, `overflow`=0
  - `byte_count`=0
  - state FILL
- **Reset mid-frame:** all partial data is discarded.

## Timing
- `op_valid` rises on the clock edge that accepts the final byte, so it is visible in the cycle after the final strobe.
- Handshake completes on the edge where `op_valid && op_ready`; `op_valid` is low the next cycle.
- No combinational path from any input to any output. All outputs are registered.
- Throughput: one byte per cycle in FILL; HOLD lasts at least one cycle.
- `byte_count` saturates at its frame length. It cannot wrap because HOLD blocks further accepts.

## Configuration
- Macro: `UART_PACKER_CHECKSUM_EN`.
- **Defined:**
  - The frame is `NUM_BYTES+1` bytes; the final byte is a checksum equal to the XOR of all data bytes.
  - The block keeps a running 8-bit XOR of the data bytes, reset at frame start.
  - On the checksum byte, `chk_err` is set to (running XOR != checksum byte). The checksum byte is not written to the shadow register.
- **Undefined:** the frame is `NUM_BYTES` bytes, `chk_err` is tied to 0, and no XOR register is built.

## Structure
- **Shared package `uart_pkg`:**
  - `UART_BYTE_W`=8
  - default frame length 48
  - adder operand width 381
  - state enum `packer_state_t` {FILL, HOLD}
- **One sub-module:** `byte_xor_acc`, an 8-bit running-XOR accumulator with a frame-start clear. It is instantiated only under `UART_PACKER_CHECKSUM_EN`.
- Everything else is flat in `uart_operand_packer`.

## Test plan
- **Basic frame (macro off):**
  - Stimulus: bytes 0x01..0x2F (47 bytes) then 0x10, `op_ready`=1.
  - Required: `op_valid` for 1 cycle, `op_data[7:0]`=0x01, `op_data[15:8]`=0x02, `op_data[380:376]`=0x10, `range_err`=0.
- **Range error:**
  - Stimulus: same frame with final byte 0xE0.
  - Required: `range_err`=1, `op_data[380:376]`=0x00.
- **Backpressure:**
  - Stimulus: full frame, `op_ready`=0, then 3 extra bytes, then `op_ready`=1.
  - Required: `op_data` unchanged throughout, `overflow`=1 and stays 1 after the handshake, `byte_count`=0 after the handshake.
- **Handshake plus byte:**
  - Stimulus: byte 0xAA strobed in the handshake cycle.
  - Required: `byte_count`=1 next cycle, `overflow` unchanged, next frame's `op_data[7:0]`=0xAA.
- **Reset/clear mid-frame:**
  - Stimulus: 20 bytes, then `rst_n` low for 1 cycle (repeat the test using `clear`), then a full fresh frame.
  - Required: all outputs at reset values after the abort; the fresh frame is delivered correctly.
- **Checksum (macro on):**
  - Stimulus: 48 bytes all 0x5A plus checksum 0x00 → `chk_err`=0.
  - Stimulus: 48 bytes all 0x5A plus checksum 0x01 → `chk_err`=1, `op_valid` still asserted.
